// File: rtl/wb_stream_bridge.sv
// -----------------------------------------------------------------------------
// wb_stream_bridge
//
// Wishbone slave that turns bus accesses into val/rdy stream traffic for an
// accelerator.
//   * Write to BASE_ADDR            : push the write data into the instruction FIFO.
//   * Write to BASE_ADDR+4+4*i      : push a load opcode (32'h0000_0000) into the
//                                     instruction FIFO and {i, data} into the load FIFO.
//   * Read of BASE_ADDR+4+4*i       : push a store opcode (32'h0800_0000) and {i, 0},
//                                     then wait for the accelerator's store data
//                                     (or time out with 32'hDEAD_BEEF and set err_o).
//   * Read of BASE_ADDR             : status word {err, 7'b0, instr cnt, load cnt, 8'b0}.
//   * Below BASE_ADDR or misaligned : acknowledged, read data 0, nothing pushed.
//
// Ports
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wbs_*                      Wishbone slave (wbs_sel_i is ignored)
//   instruction_recv_*         32-bit instruction stream out (val/rdy)
//   load_recv_*                {index, data} load stream out (val/rdy)
//   store_send_*               32-bit store data stream in (val/rdy)
//   err_o                      sticky store-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module wb_stream_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned IDX_W     = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [31:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   output logic [31:0]        instruction_recv_msg,
   output logic               instruction_recv_val,
   input  logic               instruction_recv_rdy,
   output logic [IDX_W+31:0]  load_recv_msg,
   output logic               load_recv_val,
   input  logic               load_recv_rdy,
   input  logic [31:0]        store_send_msg,
   input  logic               store_send_val,
   output logic               store_send_rdy,
   output logic               err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [31:0] OP_LOAD   = {5'b00000, 27'b0};
   localparam logic [31:0] OP_STORE  = {5'b00001, 27'b0};
   localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_STORE,
      S_ACK
   } state_e;

   // Byte enables carry no meaning for this slave.
   logic unused_sel;
   assign unused_sel = ^wbs_sel_i;

   // ---------------------------------------------------------------- state
   state_e      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] dat_q,   dat_d;
   logic        err_q,   err_d;

   // ---------------------------------------------------------------- FIFOs
   logic [31:0]       i_mem_q [DEPTH];
   logic [AW-1:0]     i_wr_ptr_q, i_wr_ptr_d, i_rd_ptr_q, i_rd_ptr_d;
   logic [CW-1:0]     i_cnt_q,    i_cnt_d;
   logic              i_push, i_pop, i_full;
   logic [31:0]       i_wdata;

   logic [IDX_W+31:0] l_mem_q [DEPTH];
   logic [AW-1:0]     l_wr_ptr_q, l_wr_ptr_d, l_rd_ptr_q, l_rd_ptr_d;
   logic [CW-1:0]     l_cnt_q,    l_cnt_d;
   logic              l_push, l_pop, l_full;
   logic [IDX_W+31:0] l_wdata;

   // ---------------------------------------------------------------- decode
   logic              req;
   logic              adr_illegal;
   logic              adr_ctrl;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       status;

   assign req         = wbs_cyc_i & wbs_stb_i;
   assign adr_illegal = (wbs_adr_i < BASE_ADDR) || (wbs_adr_i[1:0] != 2'b00);
   assign adr_ctrl    = (wbs_adr_i == BASE_ADDR);
   assign idx         = IDX_W'((wbs_adr_i - BASE_ADDR - 32'd4) >> 2);
   assign status      = {err_q, 7'b0, 8'(i_cnt_q), 8'(l_cnt_q), 8'h00};

   // Full looks only at the registered count, so a pop in the same cycle
   // never makes room for a push in that cycle.
   assign i_full = (i_cnt_q == CW'(DEPTH));
   assign l_full = (l_cnt_q == CW'(DEPTH));

   assign instruction_recv_val = (i_cnt_q != '0);
   assign instruction_recv_msg = i_mem_q[i_rd_ptr_q];
   assign load_recv_val        = (l_cnt_q != '0);
   assign load_recv_msg        = l_mem_q[l_rd_ptr_q];
   assign i_pop                = instruction_recv_val & instruction_recv_rdy;
   assign l_pop                = load_recv_val & load_recv_rdy;

   assign wbs_ack_o      = (state_q == S_ACK);
   assign store_send_rdy = (state_q == S_WAIT_STORE);
   assign wbs_dat_o      = dat_q;
   assign err_o          = err_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d = state_q;
      timer_d = timer_q;
      dat_d   = dat_q;
      err_d   = err_q;
      i_push  = 1'b0;
      l_push  = 1'b0;
      i_wdata = '0;
      l_wdata = '0;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               if (adr_illegal) begin
                  dat_d   = '0;
                  state_d = S_ACK;
               end else if (adr_ctrl) begin
                  if (!wbs_we_i) begin
                     dat_d   = status;
                     state_d = S_ACK;
                  end else if (!i_full) begin
                     i_push  = 1'b1;
                     i_wdata = wbs_dat_i;
                     dat_d   = '0;
                     state_d = S_ACK;
                  end
               end else if (!i_full && !l_full) begin
                  // Data window: opcode and operand enter their FIFOs together.
                  i_push = 1'b1;
                  l_push = 1'b1;
                  if (wbs_we_i) begin
                     i_wdata = OP_LOAD;
                     l_wdata = {idx, wbs_dat_i};
                     dat_d   = '0;
                     state_d = S_ACK;
                  end else begin
                     i_wdata = OP_STORE;
                     l_wdata = {idx, 32'h0};
                     timer_d = '0;
                     state_d = S_WAIT_STORE;
                  end
               end
            end
         end

         // Holds until data or timeout even if the master drops cyc/stb.
         S_WAIT_STORE: begin
            timer_d = timer_q + 32'd1;
            if (store_send_val) begin
               dat_d   = store_send_msg;
               state_d = S_ACK;
            end else if (timer_d == TIMEOUT) begin
               dat_d   = DEAD_BEEF;
               err_d   = 1'b1;
               state_d = S_ACK;
            end
         end

         S_ACK: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FIFO pointers
   always_comb begin
      i_wr_ptr_d = i_push ? i_wr_ptr_q + AW'(1) : i_wr_ptr_q;
      i_rd_ptr_d = i_pop  ? i_rd_ptr_q + AW'(1) : i_rd_ptr_q;
      i_cnt_d    = i_cnt_q + CW'(i_push) - CW'(i_pop);
      l_wr_ptr_d = l_push ? l_wr_ptr_q + AW'(1) : l_wr_ptr_q;
      l_rd_ptr_d = l_pop  ? l_rd_ptr_q + AW'(1) : l_rd_ptr_q;
      l_cnt_d    = l_cnt_q + CW'(l_push) - CW'(l_pop);
   end

   // ---------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         dat_q      <= '0;
         err_q      <= 1'b0;
         i_wr_ptr_q <= '0;
         i_rd_ptr_q <= '0;
         i_cnt_q    <= '0;
         l_wr_ptr_q <= '0;
         l_rd_ptr_q <= '0;
         l_cnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         dat_q      <= dat_d;
         err_q      <= err_d;
         i_wr_ptr_q <= i_wr_ptr_d;
         i_rd_ptr_q <= i_rd_ptr_d;
         i_cnt_q    <= i_cnt_d;
         l_wr_ptr_q <= l_wr_ptr_d;
         l_rd_ptr_q <= l_rd_ptr_d;
         l_cnt_q    <= l_cnt_d;
      end
   end

   // NOTE: FIFO storage has no reset; the zeroed counts keep stale entries
   // invisible, and leaving the array unreset lets it map onto plain RAM.
   always_ff @(posedge wb_clk_i) begin
      if (i_push) i_mem_q[i_wr_ptr_q] <= i_wdata;
      if (l_push) l_mem_q[l_wr_ptr_q] <= l_wdata;
   end

endmodule

// File: tb/tb_wb_stream_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_stream_bridge
//
// Directed and randomized bench for wb_stream_bridge. Expected stream contents
// live in two queues; the status word and latencies are computed from those
// queues and the access type. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_stream_bridge;

   localparam logic [31:0] BASE    = 32'h3000_0000;
   localparam int          IDX_W   = 32;
   localparam int          DEPTH   = 4;
   localparam int          TIMEOUT = 255;

   localparam logic [31:0] OP_LOAD  = 32'h0000_0000;
   localparam logic [31:0] OP_STORE = 32'h0800_0000;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i;
   logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]        wbs_sel_i;
   logic [31:0]       wbs_adr_i, wbs_dat_i;
   logic              wbs_ack_o;
   logic [31:0]       wbs_dat_o;
   logic [31:0]       instruction_recv_msg;
   logic              instruction_recv_val, instruction_recv_rdy;
   logic [IDX_W+31:0] load_recv_msg;
   logic              load_recv_val, load_recv_rdy;
   logic [31:0]       store_send_msg;
   logic              store_send_val, store_send_rdy;
   logic              err_o;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_stream_bridge #(
      .BASE_ADDR (BASE),
      .IDX_W     (IDX_W),
      .DEPTH     (DEPTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .wb_clk_i             (wb_clk_i),
      .wb_rst_i             (wb_rst_i),
      .wbs_cyc_i            (wbs_cyc_i),
      .wbs_stb_i            (wbs_stb_i),
      .wbs_we_i             (wbs_we_i),
      .wbs_sel_i            (wbs_sel_i),
      .wbs_adr_i            (wbs_adr_i),
      .wbs_dat_i            (wbs_dat_i),
      .wbs_ack_o            (wbs_ack_o),
      .wbs_dat_o            (wbs_dat_o),
      .instruction_recv_msg (instruction_recv_msg),
      .instruction_recv_val (instruction_recv_val),
      .instruction_recv_rdy (instruction_recv_rdy),
      .load_recv_msg        (load_recv_msg),
      .load_recv_val        (load_recv_val),
      .load_recv_rdy        (load_recv_rdy),
      .store_send_msg       (store_send_msg),
      .store_send_val       (store_send_val),
      .store_send_rdy       (store_send_rdy),
      .err_o                (err_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: what each stream should present, oldest first.
   logic [31:0]       iq [$];
   logic [IDX_W+31:0] lq [$];
   logic              err_exp = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_exp();
      return {err_exp, 7'b0, 8'(iq.size()), 8'(lq.size()), 8'h00};
   endfunction

   // One bus access. resp_delay > 0 drives store data in that cycle after the
   // request cycle; 0 never answers. lat is the cycle ack was seen in.
   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input int resp_delay, input logic [31:0] resp_dat,
                          output logic [31:0] rdat, output int lat);
      int  n    = 0;
      bit  done = 1'b0;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = wdat;
      lat       = -1;
      rdat      = '0;
      while (!done && n < 1000) begin
         @(negedge wb_clk_i);
         n++;
         if (wbs_ack_o) begin
            done = 1'b1;
            lat  = n;
            rdat = wbs_dat_o;
         end else if (resp_delay > 0 && n == resp_delay) begin
            check("store_rdy_in_wait", 64'(store_send_rdy), 64'd1);
            store_send_val = 1'b1;
            store_send_msg = resp_dat;
         end else begin
            store_send_val = 1'b0;
         end
      end
      wbs_cyc_i      = 1'b0;
      wbs_stb_i      = 1'b0;
      wbs_we_i       = 1'b0;
      store_send_val = 1'b0;
      if (!done) check("ack_within_bound", 64'd0, 64'd1);
      @(negedge wb_clk_i);
      check("ack_single_cycle", 64'(wbs_ack_o), 64'd0);
   endtask

   task automatic drain_all();
      int n;
      n = iq.size();
      for (int k = 0; k < n; k++) begin
         check("instr_val", 64'(instruction_recv_val), 64'd1);
         check("instr_msg", 64'(instruction_recv_msg), 64'(iq[0]));
         void'(iq.pop_front());
         instruction_recv_rdy = 1'b1;
         @(negedge wb_clk_i);
         instruction_recv_rdy = 1'b0;
      end
      check("instr_drained", 64'(instruction_recv_val), 64'd0);
      n = lq.size();
      for (int k = 0; k < n; k++) begin
         check("load_val", 64'(load_recv_val), 64'd1);
         check("load_msg", 64'(load_recv_msg), 64'(lq[0]));
         void'(lq.pop_front());
         load_recv_rdy = 1'b1;
         @(negedge wb_clk_i);
         load_recv_rdy = 1'b0;
      end
      check("load_drained", 64'(load_recv_val), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd, d, adr;
      int          lat, idx, dly, op;

      wb_rst_i             = 1'b1;
      wbs_cyc_i            = 1'b0;
      wbs_stb_i            = 1'b0;
      wbs_we_i             = 1'b0;
      wbs_sel_i            = 4'hF;
      wbs_adr_i            = '0;
      wbs_dat_i            = '0;
      instruction_recv_rdy = 1'b0;
      load_recv_rdy        = 1'b0;
      store_send_msg       = '0;
      store_send_val       = 1'b0;

      // Reset state.
      repeat (2) @(negedge wb_clk_i);
      check("rst_ack",       64'(wbs_ack_o),            64'd0);
      check("rst_dat",       64'(wbs_dat_o),            64'd0);
      check("rst_instr_val", 64'(instruction_recv_val), 64'd0);
      check("rst_load_val",  64'(load_recv_val),        64'd0);
      check("rst_store_rdy", 64'(store_send_rdy),       64'd0);
      check("rst_err",       64'(err_o),                64'd0);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      // Instruction write.
      wb_xfer(1'b1, BASE, 32'h1234_5678, 0, '0, rd, lat);
      check("instr_wr_lat", 64'(lat), 64'd1);
      iq.push_back(32'h1234_5678);
      drain_all();

      // Window write, index 2.
      wb_xfer(1'b1, 32'h3000_000C, 32'h0000_CAFE, 0, '0, rd, lat);
      check("load_wr_lat", 64'(lat), 64'd1);
      iq.push_back(OP_LOAD);
      lq.push_back({32'd2, 32'h0000_CAFE});
      drain_all();

      // Window read, index 1, store data 5 cycles after the request.
      wb_xfer(1'b0, 32'h3000_0008, '0, 5, 32'hA5A5_A5A5, rd, lat);
      check("store_rd_lat",  64'(lat), 64'd6);
      check("store_rd_data", 64'(rd),  64'hA5A5_A5A5);
      iq.push_back(OP_STORE);
      lq.push_back({32'd1, 32'h0});
      drain_all();

      // Fill the instruction FIFO; the fifth write stalls until a pop lands.
      for (int k = 0; k < DEPTH; k++) begin
         d = $urandom;
         wb_xfer(1'b1, BASE, d, 0, '0, rd, lat);
         check("fill_lat", 64'(lat), 64'd1);
         iq.push_back(d);
      end
      check("full_instr_val", 64'(instruction_recv_val), 64'd1);
      d = 32'h5555_0005;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b1;
      wbs_adr_i = BASE;
      wbs_dat_i = d;
      repeat (4) begin
         @(negedge wb_clk_i);
         check("full_stall_ack", 64'(wbs_ack_o), 64'd0);
      end
      check("full_head", 64'(instruction_recv_msg), 64'(iq[0]));
      instruction_recv_rdy = 1'b1;
      @(negedge wb_clk_i);
      instruction_recv_rdy = 1'b0;
      void'(iq.pop_front());
      check("pop_frees_next_cycle", 64'(wbs_ack_o), 64'd0);
      iq.push_back(d);
      @(negedge wb_clk_i);
      check("fifth_ack", 64'(wbs_ack_o), 64'd1);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      @(negedge wb_clk_i);
      check("fifth_ack_single", 64'(wbs_ack_o), 64'd0);
      wb_xfer(1'b0, BASE, '0, 0, '0, rd, lat);
      check("status_after_fill", 64'(rd), 64'(status_exp()));
      drain_all();

      // Master drops the request while the store is pending.
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = BASE + 32'd4;
      repeat (2) @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge wb_clk_i);
      check("abort_still_waiting", 64'(store_send_rdy), 64'd1);
      store_send_val = 1'b1;
      store_send_msg = 32'h0BAD_F00D;
      @(negedge wb_clk_i);
      store_send_val = 1'b0;
      check("abort_ack",  64'(wbs_ack_o), 64'd1);
      check("abort_data", 64'(wbs_dat_o), 64'h0BAD_F00D);
      iq.push_back(OP_STORE);
      lq.push_back({32'd0, 32'h0});
      @(negedge wb_clk_i);
      check("abort_ack_single", 64'(wbs_ack_o), 64'd0);
      drain_all();

      // Randomized mix of all access kinds.
      for (int n = 0; n < 40; n++) begin
         if (iq.size() == DEPTH || lq.size() == DEPTH) drain_all();
         op  = $urandom_range(0, 4);
         idx = $urandom_range(0, 63);
         d   = $urandom;
         case (op)
            0: begin
               wb_xfer(1'b1, BASE, d, 0, '0, rd, lat);
               check("rnd_instr_lat", 64'(lat), 64'd1);
               iq.push_back(d);
            end
            1: begin
               wb_xfer(1'b1, BASE + 32'd4 + 32'(4 * idx), d, 0, '0, rd, lat);
               check("rnd_load_lat", 64'(lat), 64'd1);
               iq.push_back(OP_LOAD);
               lq.push_back({32'(idx), d});
            end
            2: begin
               dly = $urandom_range(1, 8);
               wb_xfer(1'b0, BASE + 32'd4 + 32'(4 * idx), '0, dly, d, rd, lat);
               check("rnd_store_lat",  64'(lat), 64'(dly + 1));
               check("rnd_store_data", 64'(rd),  64'(d));
               iq.push_back(OP_STORE);
               lq.push_back({32'(idx), 32'h0});
            end
            3: begin
               wb_xfer(1'b0, BASE, '0, 0, '0, rd, lat);
               check("rnd_status_lat", 64'(lat), 64'd1);
               check("rnd_status",     64'(rd),  64'(status_exp()));
            end
            default: begin
               if (d[0]) adr = BASE - 32'(4 * (idx + 1));
               else      adr = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
               wb_xfer(d[1], adr, d, 0, '0, rd, lat);
               check("rnd_illegal_lat", 64'(lat), 64'd1);
               if (!d[1]) check("rnd_illegal_data", 64'(rd), 64'd0);
            end
         endcase
      end
      wb_xfer(1'b0, BASE, '0, 0, '0, rd, lat);
      check("rnd_final_status", 64'(rd), 64'(status_exp()));
      drain_all();

      // Store timeout.
      wb_xfer(1'b0, BASE + 32'd8, '0, 0, '0, rd, lat);
      check("timeout_lat",  64'(lat),   64'(TIMEOUT + 1));
      check("timeout_data", 64'(rd),    64'hDEAD_BEEF);
      check("timeout_err",  64'(err_o), 64'd1);
      err_exp = 1'b1;
      iq.push_back(OP_STORE);
      lq.push_back({32'd1, 32'h0});
      wb_xfer(1'b0, BASE, '0, 0, '0, rd, lat);
      check("timeout_status", 64'(rd), 64'(status_exp()));
      check("status_bit31",   64'(rd[31]), 64'd1);

      // Reset while waiting for store data.
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      wbs_we_i  = 1'b0;
      wbs_adr_i = BASE + 32'h10;
      repeat (3) @(negedge wb_clk_i);
      check("pre_rst_wait", 64'(store_send_rdy), 64'd1);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wb_rst_i  = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i  = 1'b0;
      iq.delete();
      lq.delete();
      err_exp   = 1'b0;
      check("midrst_store_rdy", 64'(store_send_rdy),       64'd0);
      check("midrst_instr_val", 64'(instruction_recv_val), 64'd0);
      check("midrst_load_val",  64'(load_recv_val),        64'd0);
      check("midrst_err",       64'(err_o),                64'd0);
      repeat (3) begin
         @(negedge wb_clk_i);
         check("midrst_no_ack", 64'(wbs_ack_o), 64'd0);
      end
      wb_xfer(1'b0, BASE, '0, 0, '0, rd, lat);
      check("post_rst_status", 64'(rd), 64'(status_exp()));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
